// File: rtl/cnn_pkg.sv
// Shared types and helpers for the streaming convolution engine.
//   conv_state_e : controller states (IDLE, STREAM, DRAIN)
//   weight_t     : signed weight at the default 8-bit width
//   acc_width    : signed result width for a KxK dot product
//   out_dim      : number of window positions along one axis
//   idx_width    : index width that stays >= 1 for single-entry ranges
package cnn_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      STREAM = 2'd1,
      DRAIN  = 2'd2
   } conv_state_e;

   localparam int DEF_WEIGHT_W = 8;
   typedef logic signed [DEF_WEIGHT_W-1:0] weight_t;

   function automatic int acc_width(input int data_w, input int weight_w, input int k);
      return data_w + weight_w + $clog2(k * k) + 1;
   endfunction

   function automatic int out_dim(input int img, input int k, input int s);
      return (img - k) / s + 1;
   endfunction

   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/conv_window_buffer.sv
// K-1 line buffers plus the KxK sliding window.
// The window presented on 'window' already includes the pixel currently on
// pix_data, so the MAC can register its result on the same edge that accepts
// the pixel. Only K x (K-1) window registers are kept; the newest column is
// taken straight from the line-buffer reads and the incoming pixel.
// Ports:
//   clk          clock
//   shift_en     pixel accepted this cycle
//   pix_data     incoming pixel
//   col, row     raster position of pix_data
//   window       tap t = r*K + c at [t*DATA_W +: DATA_W], tap 0 = top-left
//   window_valid window fully inside the current rows/columns
module conv_window_buffer import cnn_pkg::*; #(
   parameter  int IMAGE_WIDTH  = 28,
   parameter  int IMAGE_HEIGHT = 28,
   parameter  int KERNEL_SIZE  = 3,
   parameter  int DATA_W       = 8,
   localparam int COL_W        = idx_width(IMAGE_WIDTH),
   localparam int ROW_W        = idx_width(IMAGE_HEIGHT)
) (
   input  logic                                     clk,
   input  logic                                     shift_en,
   input  logic [DATA_W-1:0]                        pix_data,
   input  logic [COL_W-1:0]                         col,
   input  logic [ROW_W-1:0]                         row,
   output logic [KERNEL_SIZE*KERNEL_SIZE*DATA_W-1:0] window,
   output logic                                     window_valid
);

   localparam int K = KERNEL_SIZE;

   // line_buf[K-2] holds the previous row, line_buf[0] the oldest one
   logic [DATA_W-1:0] line_buf [K-1][IMAGE_WIDTH];
   logic [DATA_W-1:0] win_q    [K][K-1];
   logic [DATA_W-1:0] new_col  [K];

   always_comb begin
      for (int r = 0; r < K - 1; r++) begin
         new_col[r] = line_buf[r][col];
      end
      new_col[K-1] = pix_data;
   end

   // Contents need no reset: validity comes from the row/col position.
   always_ff @(posedge clk) begin
      if (shift_en) begin
         for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K - 2; c++) begin
               win_q[r][c] <= win_q[r][c+1];
            end
            win_q[r][K-2] <= new_col[r];
         end
         for (int r = 0; r < K - 2; r++) begin
            line_buf[r][col] <= line_buf[r+1][col];
         end
         line_buf[K-2][col] <= pix_data;
      end
   end

   always_comb begin
      window = '0;
      for (int r = 0; r < K; r++) begin
         for (int c = 0; c < K - 1; c++) begin
            window[(r*K+c)*DATA_W +: DATA_W] = win_q[r][c];
         end
         window[(r*K+K-1)*DATA_W +: DATA_W] = new_col[r];
      end
   end

   // Column wrap drops validity: stale columns from the previous row are
   // only ever seen while col < K-1.
   assign window_valid = (int'(row) >= K - 1) && (int'(col) >= K - 1);

endmodule

// File: rtl/conv_stream_engine.sv
// Streaming multi-feature 2D convolution engine.
// One raster-order pixel per handshake; every valid window position yields
// one output beat carrying all NUM_FEATURES dot products, one cycle after the
// pixel that completes the window.
// Build option: CONV_RELU_EN clamps negative feature results to zero.
// Ports:
//   clk, rst_cnn                 clock, async active-low reset
//   start, busy, frame_done      frame control / status
//   w_wr_en, w_feature, w_tap,
//   w_data                       weight load (IDLE only)
//   pix_valid/ready/data         pixel stream in
//   out_valid/ready/data,
//   out_row, out_col             result stream out
//
// state  | meaning
// IDLE   | waiting for start, weights writable
// STREAM | accepting pixels of a frame
// DRAIN  | last pixel taken, waiting for the output register to empty
module conv_stream_engine import cnn_pkg::*; #(
   parameter  int IMAGE_WIDTH  = 28,
   parameter  int IMAGE_HEIGHT = 28,
   parameter  int NUM_FEATURES = 10,
   parameter  int KERNEL_SIZE  = 3,
   parameter  int STRIDE       = 1,
   parameter  int DATA_W       = 8,
   parameter  int WEIGHT_W     = 8,
   localparam int ACC_W  = acc_width(DATA_W, WEIGHT_W, KERNEL_SIZE),
   localparam int OUT_W  = out_dim(IMAGE_WIDTH, KERNEL_SIZE, STRIDE),
   localparam int OUT_H  = out_dim(IMAGE_HEIGHT, KERNEL_SIZE, STRIDE),
   localparam int TAPS   = KERNEL_SIZE * KERNEL_SIZE,
   localparam int FEAT_W = idx_width(NUM_FEATURES),
   localparam int TAP_W  = idx_width(TAPS),
   localparam int OROW_W = idx_width(OUT_H),
   localparam int OCOL_W = idx_width(OUT_W),
   localparam int COL_W  = idx_width(IMAGE_WIDTH),
   localparam int ROW_W  = idx_width(IMAGE_HEIGHT)
) (
   input  logic                          clk,
   input  logic                          rst_cnn,
   input  logic                          start,
   output logic                          busy,
   output logic                          frame_done,
   input  logic                          w_wr_en,
   input  logic [FEAT_W-1:0]             w_feature,
   input  logic [TAP_W-1:0]              w_tap,
   input  logic [WEIGHT_W-1:0]           w_data,
   input  logic                          pix_valid,
   output logic                          pix_ready,
   input  logic [DATA_W-1:0]             pix_data,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [NUM_FEATURES*ACC_W-1:0] out_data,
   output logic [OROW_W-1:0]             out_row,
   output logic [OCOL_W-1:0]             out_col
);

   conv_state_e state, state_next;

   logic [COL_W-1:0]              col;
   logic [ROW_W-1:0]              row;
   logic                          pix_acc;
   logic                          last_pix;
   logic                          emit;
   logic [OROW_W-1:0]             orow_n;
   logic [OCOL_W-1:0]             ocol_n;
   logic signed [WEIGHT_W-1:0]    weights [NUM_FEATURES][TAPS];
   logic [TAPS*DATA_W-1:0]        window;
   logic                          window_valid;
   logic [NUM_FEATURES*ACC_W-1:0] mac_data;

   assign busy      = (state != IDLE);
   assign pix_ready = (state == STREAM) && (!out_valid || out_ready);
   assign pix_acc   = pix_valid && pix_ready;
   assign last_pix  = (int'(row) == IMAGE_HEIGHT - 1) && (int'(col) == IMAGE_WIDTH - 1);

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (start) state_next = STREAM;
         STREAM:  if (pix_acc && last_pix) state_next = DRAIN;
         DRAIN:   if (!out_valid || out_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_cnn) begin
      if (!rst_cnn) begin
         state      <= IDLE;
         frame_done <= 1'b0;
      end else begin
         state      <= state_next;
         frame_done <= (state == DRAIN) && (state_next == IDLE);
      end
   end

   always_ff @(posedge clk or negedge rst_cnn) begin
      if (!rst_cnn) begin
         col <= '0;
         row <= '0;
      end else if (pix_acc) begin
         if (int'(col) == IMAGE_WIDTH - 1) begin
            col <= '0;
            row <= (int'(row) == IMAGE_HEIGHT - 1) ? '0 : row + ROW_W'(1);
         end else begin
            col <= col + COL_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_cnn) begin
      if (!rst_cnn) begin
         for (int f = 0; f < NUM_FEATURES; f++) begin
            for (int t = 0; t < TAPS; t++) begin
               weights[f][t] <= '0;
            end
         end
      end else if ((state == IDLE) && w_wr_en &&
                   (int'(w_feature) < NUM_FEATURES) && (int'(w_tap) < TAPS)) begin
         weights[w_feature][w_tap] <= w_data;
      end
   end

   conv_window_buffer #(
      .IMAGE_WIDTH  (IMAGE_WIDTH),
      .IMAGE_HEIGHT (IMAGE_HEIGHT),
      .KERNEL_SIZE  (KERNEL_SIZE),
      .DATA_W       (DATA_W)
   ) u_window (
      .clk          (clk),
      .shift_en     (pix_acc),
      .pix_data     (pix_data),
      .col          (col),
      .row          (row),
      .window       (window),
      .window_valid (window_valid)
   );

   // Offsets are negative while the window is not yet valid; emit masks that.
   always_comb begin
      int r_off;
      int c_off;
      r_off  = int'(row) - (KERNEL_SIZE - 1);
      c_off  = int'(col) - (KERNEL_SIZE - 1);
      emit   = window_valid && (r_off % STRIDE == 0) && (c_off % STRIDE == 0);
      orow_n = OROW_W'(r_off / STRIDE);
      ocol_n = OCOL_W'(c_off / STRIDE);
   end

   // Pixels are zero-extended to stay positive; ACC_W leaves headroom for
   // every tap at full scale, so the sum never wraps.
   always_comb begin
      logic signed [ACC_W-1:0] acc;
      logic signed [ACC_W-1:0] px;
      logic signed [ACC_W-1:0] wt;
      acc      = '0;
      px       = '0;
      wt       = '0;
      mac_data = '0;
      for (int f = 0; f < NUM_FEATURES; f++) begin
         acc = '0;
         for (int t = 0; t < TAPS; t++) begin
            px  = ACC_W'($signed({1'b0, window[t*DATA_W +: DATA_W]}));
            wt  = ACC_W'(weights[f][t]);
            acc = acc + px * wt;
         end
`ifdef CONV_RELU_EN
         if (acc[ACC_W-1]) acc = '0;
`endif
         mac_data[f*ACC_W +: ACC_W] = acc;
      end
   end

   // pix_acc implies the register is empty or being drained this cycle,
   // so a new beat never overwrites an unaccepted one.
   always_ff @(posedge clk or negedge rst_cnn) begin
      if (!rst_cnn) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_row   <= '0;
         out_col   <= '0;
      end else if (pix_acc && emit) begin
         out_valid <= 1'b1;
         out_data  <= mac_data;
         out_row   <= orow_n;
         out_col   <= ocol_n;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_conv_stream_engine.sv
module tb_conv_stream_engine;

   localparam int AW = 21;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_cnn;
   logic [0:0] w_feature;
   logic [3:0] w_tap;
   logic [7:0] w_data;
   logic [7:0] pix_data;

   logic          a_start, a_w_wr_en, a_pix_valid, a_out_ready;
   logic          a_busy, a_frame_done, a_pix_ready, a_out_valid;
   logic [2*AW-1:0] a_out_data;
   logic [0:0]    a_out_row, a_out_col;

   logic          b_start, b_w_wr_en, b_pix_valid, b_out_ready;
   logic          b_busy, b_frame_done, b_pix_ready, b_out_valid;
   logic [2*AW-1:0] b_out_data;
   logic [0:0]    b_out_row, b_out_col;

   conv_stream_engine #(
      .IMAGE_WIDTH(4), .IMAGE_HEIGHT(4), .NUM_FEATURES(2),
      .KERNEL_SIZE(3), .STRIDE(1), .DATA_W(8), .WEIGHT_W(8)
   ) dut_a (
      .clk(clk), .rst_cnn(rst_cnn), .start(a_start), .busy(a_busy),
      .frame_done(a_frame_done), .w_wr_en(a_w_wr_en), .w_feature(w_feature),
      .w_tap(w_tap), .w_data(w_data), .pix_valid(a_pix_valid),
      .pix_ready(a_pix_ready), .pix_data(pix_data), .out_valid(a_out_valid),
      .out_ready(a_out_ready), .out_data(a_out_data), .out_row(a_out_row),
      .out_col(a_out_col)
   );

   conv_stream_engine #(
      .IMAGE_WIDTH(6), .IMAGE_HEIGHT(6), .NUM_FEATURES(2),
      .KERNEL_SIZE(3), .STRIDE(2), .DATA_W(8), .WEIGHT_W(8)
   ) dut_b (
      .clk(clk), .rst_cnn(rst_cnn), .start(b_start), .busy(b_busy),
      .frame_done(b_frame_done), .w_wr_en(b_w_wr_en), .w_feature(w_feature),
      .w_tap(w_tap), .w_data(w_data), .pix_valid(b_pix_valid),
      .pix_ready(b_pix_ready), .pix_data(pix_data), .out_valid(b_out_valid),
      .out_ready(b_out_ready), .out_data(b_out_data), .out_row(b_out_row),
      .out_col(b_out_col)
   );

   typedef struct {
      int row;
      int col;
      int f0;
      int f1;
   } beat_t;

   beat_t qa[$];
   beat_t qb[$];

   int checks = 0;
   int errors = 0;
   int fd_a = 0, fd_b = 0, beats_a = 0, beats_b = 0;
   int wm [2][2][9];
   int img [36];
   int stall_at = -1;
   int poke_at  = -1;

   task automatic chk(input string tag, input longint obs, input longint exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drv(input int which, input logic st, input logic we, input logic pv);
      if (which == 0) begin
         a_start = st; a_w_wr_en = we; a_pix_valid = pv;
      end else begin
         b_start = st; b_w_wr_en = we; b_pix_valid = pv;
      end
   endtask

   function automatic logic rdy(input int which);
      return (which == 0) ? a_pix_ready : b_pix_ready;
   endfunction

   task automatic write_w(input int which, input int f, input int t, input int d);
      w_feature = 1'(f);
      w_tap     = 4'(t);
      w_data    = 8'(d);
      drv(which, 1'b0, 1'b1, 1'b0);
      tick();
      drv(which, 1'b0, 1'b0, 1'b0);
      wm[which][f][t] = d;
   endtask

   // Scoreboard pop on every output handshake.
   task automatic take(input int which);
      beat_t e;
      logic [2*AW-1:0] d;
      int r, c, qs;
      string p;
      p  = (which == 0) ? "a_" : "b_";
      d  = (which == 0) ? a_out_data : b_out_data;
      r  = (which == 0) ? int'(a_out_row) : int'(b_out_row);
      c  = (which == 0) ? int'(a_out_col) : int'(b_out_col);
      qs = (which == 0) ? qa.size() : qb.size();
      chk({p, "beat_expected"}, longint'(qs > 0), 1);
      if (qs > 0) begin
         e = (which == 0) ? qa.pop_front() : qb.pop_front();
         chk({p, "out_row"}, r, e.row);
         chk({p, "out_col"}, c, e.col);
         chk({p, "feat0"}, longint'($signed(d[AW-1:0])), e.f0);
         chk({p, "feat1"}, longint'($signed(d[2*AW-1:AW])), e.f1);
      end
   endtask

   always @(negedge clk) begin
      if (a_frame_done) fd_a++;
      if (b_frame_done) fd_b++;
      if (a_out_valid && a_out_ready) begin
         beats_a++;
         take(0);
      end
      if (b_out_valid && b_out_ready) begin
         beats_b++;
         take(1);
      end
   end

   task automatic run_frame(input int which, input int w, input int h, input int s,
                            input int abort_after);
      int ow, oh, n, fd0, bt0, acc;
      longint held;
      beat_t e;
      string p;
      p  = (which == 0) ? "a_" : "b_";
      ow = (w - 3) / s + 1;
      oh = (h - 3) / s + 1;
      for (int orow = 0; orow < oh; orow++) begin
         for (int ocol = 0; ocol < ow; ocol++) begin
            e.row = orow;
            e.col = ocol;
            e.f0  = 0;
            e.f1  = 0;
            for (int f = 0; f < 2; f++) begin
               acc = 0;
               for (int i = 0; i < 3; i++)
                  for (int j = 0; j < 3; j++)
                     acc += img[(orow*s+i)*w + ocol*s + j] * wm[which][f][i*3+j];
`ifdef CONV_RELU_EN
               if (acc < 0) acc = 0;
`endif
               if (f == 0) e.f0 = acc; else e.f1 = acc;
            end
            if (which == 0) qa.push_back(e); else qb.push_back(e);
         end
      end
      fd0 = (which == 0) ? fd_a : fd_b;
      bt0 = (which == 0) ? beats_a : beats_b;

      drv(which, 1'b1, 1'b0, 1'b0);
      tick();
      drv(which, 1'b0, 1'b0, 1'b0);
      chk({p, "busy_after_start"}, longint'((which == 0) ? a_busy : b_busy), 1);

      for (int i = 0; i < w * h; i++) begin
         if (i == abort_after) break;
         pix_data = 8'(img[i]);
         if (i == poke_at) begin
            w_feature = 1'b0;
            w_tap     = 4'd0;
            w_data    = 8'h05;
            drv(which, 1'b1, 1'b1, 1'b1);
         end else begin
            drv(which, 1'b0, 1'b0, 1'b1);
         end
         if (i == stall_at) begin
            a_out_ready = 1'b0;
            #1;
            held = longint'(a_out_data);
            for (int k = 0; k < 5; k++) begin
               chk("stall_pix_ready", longint'(a_pix_ready), 0);
               chk("stall_out_valid", longint'(a_out_valid), 1);
               chk("stall_out_data", longint'(a_out_data), held);
               tick();
            end
            a_out_ready = 1'b1;
         end
         #1;
         n = 0;
         while (!rdy(which) && n < 50) begin
            tick();
            #1;
            n++;
         end
         chk({p, "pix_accept"}, longint'(rdy(which)), 1);
         tick();
      end
      drv(which, 1'b0, 1'b0, 1'b0);
      if (abort_after >= 0) return;

      n = 0;
      while (((which == 0) ? fd_a : fd_b) == fd0 && n < 100) begin
         tick();
         n++;
      end
      repeat (3) tick();
      chk({p, "frame_done_pulses"}, ((which == 0) ? fd_a : fd_b) - fd0, 1);
      chk({p, "beat_count"}, ((which == 0) ? beats_a : beats_b) - bt0, ow * oh);
      chk({p, "queue_empty"}, (which == 0) ? qa.size() : qb.size(), 0);
      chk({p, "busy_end"}, longint'((which == 0) ? a_busy : b_busy), 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_cnn = 1'b0;
      w_feature = '0; w_tap = '0; w_data = '0; pix_data = '0;
      a_start = 0; a_w_wr_en = 0; a_pix_valid = 0; a_out_ready = 1;
      b_start = 0; b_w_wr_en = 0; b_pix_valid = 0; b_out_ready = 1;
      for (int x = 0; x < 2; x++)
         for (int f = 0; f < 2; f++)
            for (int t = 0; t < 9; t++) wm[x][f][t] = 0;
      repeat (2) tick();

      chk("rst_busy", longint'(a_busy), 0);
      chk("rst_frame_done", longint'(a_frame_done), 0);
      chk("rst_out_valid", longint'(a_out_valid), 0);
      chk("rst_pix_ready", longint'(a_pix_ready), 0);
      chk("rst_out_data", longint'(a_out_data), 0);
      chk("rst_out_row", longint'(a_out_row), 0);
      chk("rst_out_col", longint'(a_out_col), 0);
      chk("rst_b_busy", longint'(b_busy), 0);
      chk("rst_b_out_valid", longint'(b_out_valid), 0);
      rst_cnn = 1'b1;
      tick();

      // weights reset to zero: every result is zero
      for (int i = 0; i < 16; i++) img[i] = i;
      run_frame(0, 4, 4, 1, -1);

      // test 1: all weights 1, pixels 0..15
      for (int f = 0; f < 2; f++)
         for (int t = 0; t < 9; t++) write_w(0, f, t, 1);
      run_frame(0, 4, 4, 1, -1);

      // test 3: output back-pressure mid-frame
      stall_at = 11;
      run_frame(0, 4, 4, 1, -1);
      stall_at = -1;

      // test 5: weight write and start during STREAM are ignored
      poke_at = 6;
      run_frame(0, 4, 4, 1, -1);
      poke_at = -1;

      // test 4: negative feature
      for (int t = 0; t < 9; t++) begin
         write_w(0, 0, t, 1);
         write_w(0, 1, t, -1);
      end
      for (int i = 0; i < 16; i++) img[i] = 255;
      run_frame(0, 4, 4, 1, -1);

      // mixed weights, random pixels
      for (int t = 0; t < 9; t++) begin
         write_w(0, 0, t, t - 4);
         write_w(0, 1, t, int'($urandom_range(0, 255)) - 128);
      end
      for (int i = 0; i < 16; i++) img[i] = int'($urandom_range(0, 255));
      run_frame(0, 4, 4, 1, -1);

      // test 2: stride 2 on 6x6
      for (int f = 0; f < 2; f++)
         for (int t = 0; t < 9; t++) write_w(1, f, t, 1);
      for (int i = 0; i < 36; i++) img[i] = 1;
      run_frame(1, 6, 6, 2, -1);

      for (int t = 0; t < 9; t++) begin
         write_w(1, 0, t, int'($urandom_range(0, 255)) - 128);
         write_w(1, 1, t, 8 - 2 * t);
      end
      for (int i = 0; i < 36; i++) img[i] = int'($urandom_range(0, 255));
      run_frame(1, 6, 6, 2, -1);

      // test 6: reset mid-frame, then a clean rerun of test 1
      for (int f = 0; f < 2; f++)
         for (int t = 0; t < 9; t++) write_w(0, f, t, 1);
      for (int i = 0; i < 16; i++) img[i] = i;
      run_frame(0, 4, 4, 1, 12);
      rst_cnn = 1'b0;
      #1;
      chk("midrst_out_valid", longint'(a_out_valid), 0);
      chk("midrst_busy", longint'(a_busy), 0);
      chk("midrst_pix_ready", longint'(a_pix_ready), 0);
      chk("midrst_out_data", longint'(a_out_data), 0);
      qa.delete();
      for (int x = 0; x < 2; x++)
         for (int f = 0; f < 2; f++)
            for (int t = 0; t < 9; t++) wm[x][f][t] = 0;
      tick();
      rst_cnn = 1'b1;
      tick();
      for (int f = 0; f < 2; f++)
         for (int t = 0; t < 9; t++) write_w(0, f, t, 1);
      run_frame(0, 4, 4, 1, -1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
